// File: rtl/sap_ctrl_seq_pkg.sv
// Shared definitions for the SAP-1 controller-sequencer: opcodes, one-hot
// T-state constants, control-word bit positions and the idle control word.
package sap_ctrl_seq_pkg;

    localparam int CW_W = 12;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam int CW_CP        = 11;
    localparam int CW_EP        = 10;
    localparam int CW_LM_N      = 9;
    localparam int CW_CE_N      = 8;
    localparam int CW_LI_N      = 7;
    localparam int CW_EI_N      = 6;
    localparam int CW_LA_N      = 5;
    localparam int CW_EA        = 4;
    localparam int CW_SUB       = 3;
    localparam int CW_ALU_OUT_N = 2;
    localparam int CW_LB_N      = 1;
    localparam int CW_LO_N      = 0;

    // Active-high strobes low, active-low strobes high.
    localparam logic [CW_W-1:0] CW_IDLE = 12'b0011_1110_0111;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/sap_ctrl_seq_ring_counter_6.sv
// One-hot 6-state ring counter (T1..T6) with sync active-low reset, advance
// enable and a synchronous wrap-to-T1 used for variable-length machine cycles.
module ring_counter_6
    import sap_ctrl_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       wrap,
    output logic [5:0] t_state
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            t_state <= T1;
        else if (en)
            t_state <= wrap ? T1 : {t_state[4:0], t_state[5]};
    end

endmodule

// File: rtl/sap_ctrl_seq.sv
// SAP-1 controller-sequencer: ring counter plus combinational control-word decode.
// Optional SAP_VAR_MCYCLE_EN shortens the machine cycle after the last busy T-state.
module sap_ctrl_seq
    import sap_ctrl_seq_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int NUM_T    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] ir_opcode,
    output logic [NUM_T-1:0]    t_state,
    output logic                halted,
    output logic                cp,
    output logic                ep,
    output logic                lm_n,
    output logic                ce_n,
    output logic                li_n,
    output logic                ei_n,
    output logic                la_n,
    output logic                ea,
    output logic                sub,
    output logic                alu_out_en_n,
    output logic                lb_n,
    output logic                lo_n
);

    logic            hlt_now;
    logic            en;
    logic            wrap;
    logic [CW_W-1:0] cw;

    // The HLT edge must not also advance the ring, so T4 stays frozen.
    assign hlt_now = (t_state == T4) && (ir_opcode == OP_HLT) && !halted;
    assign en      = run && !halted && !hlt_now;

`ifdef SAP_VAR_MCYCLE_EN
    assign wrap = ((t_state == T5) && (ir_opcode == OP_LDA)) ||
                  ((t_state == T4) && !is_alu_op(ir_opcode) &&
                   (ir_opcode != OP_LDA) && (ir_opcode != OP_HLT));
`else
    assign wrap = 1'b0;
`endif

    ring_counter_6 u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .wrap    (wrap),
        .t_state (t_state)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            halted <= 1'b0;
        else if (run && hlt_now)
            halted <= 1'b1;
    end

    // Opcode is only looked at in T4..T6; fetch states ignore it.
    always_comb begin
        cw = CW_IDLE;
        if (rst_n && !halted) begin
            case (t_state)
                T1: begin
                    cw[CW_EP]   = 1'b1;
                    cw[CW_LM_N] = 1'b0;
                end
                T2: cw[CW_CP] = 1'b1;
                T3: begin
                    cw[CW_CE_N] = 1'b0;
                    cw[CW_LI_N] = 1'b0;
                end
                T4: begin
                    if ((ir_opcode == OP_LDA) || is_alu_op(ir_opcode)) begin
                        cw[CW_EI_N] = 1'b0;
                        cw[CW_LM_N] = 1'b0;
                    end else if (ir_opcode == OP_OUT) begin
                        cw[CW_EA]   = 1'b1;
                        cw[CW_LO_N] = 1'b0;
                    end
                end
                T5: begin
                    if (ir_opcode == OP_LDA) begin
                        cw[CW_CE_N] = 1'b0;
                        cw[CW_LA_N] = 1'b0;
                    end else if (is_alu_op(ir_opcode)) begin
                        cw[CW_CE_N] = 1'b0;
                        cw[CW_LB_N] = 1'b0;
                        // Early sub gives the complement path a full cycle to settle.
                        cw[CW_SUB]  = (ir_opcode == OP_SUB);
                    end
                end
                T6: begin
                    if (is_alu_op(ir_opcode)) begin
                        cw[CW_ALU_OUT_N] = 1'b0;
                        cw[CW_LA_N]      = 1'b0;
                        cw[CW_SUB]       = (ir_opcode == OP_SUB);
                    end
                end
                default: cw = CW_IDLE;
            endcase
        end
    end

    assign cp           = cw[CW_CP];
    assign ep           = cw[CW_EP];
    assign lm_n         = cw[CW_LM_N];
    assign ce_n         = cw[CW_CE_N];
    assign li_n         = cw[CW_LI_N];
    assign ei_n         = cw[CW_EI_N];
    assign la_n         = cw[CW_LA_N];
    assign ea           = cw[CW_EA];
    assign sub          = cw[CW_SUB];
    assign alu_out_en_n = cw[CW_ALU_OUT_N];
    assign lb_n         = cw[CW_LB_N];
    assign lo_n         = cw[CW_LO_N];

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Self-checking bench for sap_ctrl_seq against a T-index/halt reference model.
module tb_sap_ctrl_seq;

    localparam logic [3:0] LDA = 4'b0000;
    localparam logic [3:0] ADD = 4'b0001;
    localparam logic [3:0] SUB = 4'b0010;
    localparam logic [3:0] OUT = 4'b1110;
    localparam logic [3:0] HLT = 4'b1111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] ir_opcode = 4'b0000;
    logic [5:0] t_state;
    logic       halted, cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, sub, alu_out_en_n, lb_n, lo_n;
    logic [18:0] obs;

    int m_t = 1;
    bit m_h = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    sap_ctrl_seq dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ir_opcode(ir_opcode),
        .t_state(t_state), .halted(halted), .cp(cp), .ep(ep), .lm_n(lm_n),
        .ce_n(ce_n), .li_n(li_n), .ei_n(ei_n), .la_n(la_n), .ea(ea), .sub(sub),
        .alu_out_en_n(alu_out_en_n), .lb_n(lb_n), .lo_n(lo_n)
    );

    always #5 clk = ~clk;

    assign obs = {t_state, halted, cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, sub,
                  alu_out_en_n, lb_n, lo_n};

    function automatic logic [5:0] oh(input int t);
        logic [5:0] v;
        v = 6'b000001;
        return v << (t - 1);
    endfunction

    // Expected control word straight from the instruction tables.
    function automatic logic [11:0] exp_word(input int t, input logic [3:0] op, input bit h,
                                             input logic rst);
        logic c_p, e_p, lm, ce, li, ei, la, e_a, sb, alu, lb, lo;
        bit   arith;
        c_p = 0; e_p = 0; lm = 1; ce = 1; li = 1; ei = 1; la = 1; e_a = 0; sb = 0;
        alu = 1; lb = 1; lo = 1;
        arith = (op == ADD) || (op == SUB);
        if (rst && !h) begin
            case (t)
                1: begin e_p = 1; lm = 0; end
                2: c_p = 1;
                3: begin ce = 0; li = 0; end
                4: if (op == LDA || arith) begin ei = 0; lm = 0; end
                   else if (op == OUT) begin e_a = 1; lo = 0; end
                5: if (op == LDA) begin ce = 0; la = 0; end
                   else if (arith) begin ce = 0; lb = 0; sb = (op == SUB); end
                6: if (arith) begin alu = 0; la = 0; sb = (op == SUB); end
                default: ;
            endcase
        end
        return {c_p, e_p, lm, ce, li, ei, la, e_a, sb, alu, lb, lo};
    endfunction

    function automatic int last_t(input logic [3:0] op);
`ifdef SAP_VAR_MCYCLE_EN
        if (op == LDA) return 5;
        if (op == ADD || op == SUB || op == HLT) return 6;
        return 4;
`else
        return 6;
`endif
    endfunction

    function automatic logic [18:0] expv();
        return {oh(m_t), m_h, exp_word(m_t, ir_opcode, m_h, rst_n)};
    endfunction

    function automatic int drivers();
        return int'(ep) + int'(!ce_n) + int'(!ei_n) + int'(ea) + int'(!alu_out_en_n);
    endfunction

    task automatic tick();
        int nt;
        bit nh;
        nt = m_t;
        nh = m_h;
        if (!rst_n) begin
            nt = 1; nh = 0;
        end else if (!m_h && run) begin
            if (m_t == 4 && ir_opcode == HLT) nh = 1;
            else if (m_t == last_t(ir_opcode) || m_t == 6) nt = 1;
            else nt = m_t + 1;
        end
        @(posedge clk);
        #1;
        m_t = nt;
        m_h = nh;
    endtask

    task automatic test_reset();
        rst_n = 0; run = 1; ir_opcode = ADD;
        tick(); tick();
        #1; n_checks++;
        if (obs !== expv()) begin
            n_fail++; $display("FAIL reset: got %b exp %b", obs, expv());
        end
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            #1; n_checks++;
            if (obs !== expv()) begin
                n_fail++; $display("FAIL ring T%0d: got %b exp %b", m_t, obs, expv());
            end
            tick();
        end
        n_checks++;
        if (t_state !== 6'b000001) begin
            n_fail++; $display("FAIL ring_wrap: got %b exp 000001", t_state);
        end
    endtask

    task automatic test_lda();
        for (int i = 0; i < 8; i++) begin
            ir_opcode = (m_t <= 3) ? 4'($urandom_range(15)) : LDA;
            #1; n_checks++;
            if (obs !== expv()) begin
                n_fail++; $display("FAIL lda T%0d: got %b exp %b", m_t, obs, expv());
            end
            tick();
            if (m_t == 1) break;
        end
    endtask

    task automatic test_sub_add();
        logic [3:0] ops [2];
        ops[0] = SUB; ops[1] = ADD;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                ir_opcode = (m_t <= 3) ? 4'($urandom_range(15)) : ops[k];
                #1; n_checks++;
                if (obs !== expv()) begin
                    n_fail++;
                    $display("FAIL alu op=%b T%0d: got %b exp %b", ops[k], m_t, obs, expv());
                end
                tick();
                if (m_t == 1) break;
            end
        end
    endtask

    task automatic test_hlt();
        ir_opcode = HLT; run = 1;
        for (int i = 0; i < 4; i++) begin
            #1; n_checks++;
            if (obs !== expv()) begin
                n_fail++; $display("FAIL hlt_fetch T%0d: got %b exp %b", m_t, obs, expv());
            end
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            run = 1'($urandom_range(1));
            ir_opcode = 4'($urandom_range(15));
            #1; n_checks++;
            if (obs !== expv() || t_state !== 6'b001000 || halted !== 1'b1) begin
                n_fail++; $display("FAIL hlt_frozen: got %b exp %b", obs, expv());
            end
            tick();
        end
        rst_n = 0;
        tick();
        rst_n = 1; run = 1;
        #1; n_checks++;
        if (obs !== expv() || t_state !== 6'b000001 || halted !== 1'b0) begin
            n_fail++; $display("FAIL hlt_reset: got %b exp %b", obs, expv());
        end
    endtask

    task automatic test_stall_reset();
        ir_opcode = ADD; run = 1;
        for (int i = 0; i < 8 && m_t != 5; i++) begin
            #1; n_checks++;
            if (obs !== expv()) begin
                n_fail++; $display("FAIL stall_pre T%0d: got %b exp %b", m_t, obs, expv());
            end
            tick();
        end
        run = 0;
        for (int i = 0; i < 3; i++) begin
            #1; n_checks++;
            if (obs !== expv() || t_state !== 6'b010000 || lb_n !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold: got %b exp %b", obs, expv());
            end
            tick();
        end
        run = 1; rst_n = 0;
        tick();
        #1; n_checks++;
        if (obs !== expv() || t_state !== 6'b000001) begin
            n_fail++; $display("FAIL stall_reset: got %b exp %b", obs, expv());
        end
        rst_n = 1;
        #1; n_checks++;
        if (obs !== expv()) begin
            n_fail++; $display("FAIL stall_resume: got %b exp %b", obs, expv());
        end
    endtask

    task automatic test_sweep();
        for (int op = 0; op < 16; op++) begin
            rst_n = 0; tick();
            rst_n = 1; run = 1; ir_opcode = 4'(op);
            for (int i = 0; i < 8; i++) begin
                #1; n_checks++;
                if (obs !== expv() || drivers() > 1) begin
                    n_fail++;
                    $display("FAIL sweep op=%b T%0d: got %b exp %b drivers=%0d",
                             4'(op), m_t, obs, expv(), drivers());
                end
                tick();
                if (m_t == 1 || m_h) break;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(39) != 0);
            run = ($urandom_range(4) != 0);
            ir_opcode = 4'($urandom_range(15));
            #1; n_checks++;
            if (obs !== expv() || drivers() > 1) begin
                n_fail++;
                $display("FAIL random cyc=%0d: got %b exp %b drivers=%0d", i, obs, expv(), drivers());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_sub_add();
        test_hlt();
        test_stall_reset();
        test_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
